mem_loader: RTL and testbench
=============================

Name: mem_loader

Overview:
Writer-side companion to the max-finder datapath. It accepts a stream of data words over a valid/ready handshake and writes them into sequential addresses 0..MAXADDR of the data memory through a registered write port. It then signals done, so the max-finder can scan the filled memory. Controller FSM and datapath (address counter, write-port registers) sit in one block.

Parameters:
AW, 4, address width in bits
DW, 4, data width in bits
MAXADDR, 4'hf, last address written; a load is MAXADDR+1 words

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clock clk
start  input  1  pulse: begin a load at address 0
in_valid  input  1  producer has a word on in_data
in_data  input  DW  word to write
in_ready  output  1  loader accepts a word this cycle
we  output  1  memory write enable (registered)
waddr  output  AW  memory write address (registered)
wdata  output  DW  memory write data (registered)
busy  output  1  FSM in LOAD
done  output  1  load complete, memory holds MAXADDR+1 new words

Behaviour:
- Reset is synchronous, active-high. It forces state=IDLE, addr=0, we=0, waddr=0, wdata=0, done=0, busy=0, in_ready=0.
- FSM states:
  - IDLE: start -> LOAD with addr<=0.
  - LOAD: on each handshake (in_valid && in_ready), write the word. If addr==MAXADDR, go to DONE; otherwise addr<=addr+1.
  - DONE: start -> LOAD with addr<=0 and done cleared. Otherwise hold.
- Outputs by state:
  - in_ready = (state==LOAD), combinational from state only; it never depends on in_valid.
  - busy = (state==LOAD).
  - done = (state==DONE).
- Write port:
  - A handshake in cycle N produces we=1, waddr=addr-at-N, wdata=in_data-at-N in cycle N+1. Latency is 1 cycle.
  - we=0 in every cycle not immediately following a handshake.
  - waddr/wdata hold their last values when we=0.
- Throughput: one word per cycle when in_valid is held high. A full load takes MAXADDR+1 handshake cycles. done rises in the cycle after the last handshake, the same cycle the last write (we=1, waddr=MAXADDR) is presented.
- Back-pressure: in_valid low in LOAD stalls the load. addr is held and no write is issued. Any number of idle cycles is allowed.
- start while in LOAD: ignored. The load continues and addr is unaffected.
- start in the same cycle as the final handshake: the FSM goes to DONE. That start is ignored and must be re-issued.
- in_valid in IDLE or DONE: ignored. in_ready=0, no write occurs.
- Address arithmetic is AW bits wide. addr never wraps past MAXADDR, because the transition to DONE occurs instead. With MAXADDR=2^AW-1 the increment is never evaluated at the top value.
- Reset mid-load: at the next edge the block returns to IDLE and we=0. A write pending from the previous cycle's handshake is dropped. Memory contents already written are not restored.

Test Plan:
1. Reset then idle: assert reset 2 cycles, drive in_valid=1 with start=0 for 5 cycles -> in_ready=0, we=0, busy=0, done=0 throughout.
2. Full streaming load: pulse start, then in_valid=1 with in_data=15-i for i=0..15 -> 16 writes on consecutive cycles with waddr=i and wdata=15-i. done=1 the cycle after the 16th handshake. busy=0 thereafter.
3. Back-pressure: same load with in_valid low every other cycle -> only 16 writes, addresses strictly 0..15 in order, we never high after a non-handshake cycle. Total duration 31 cycles from first handshake to done.
4. Ignored start: pulse start again after 5 words are accepted -> the next write is waddr=5, not 0. Load completes normally at address 15.
5. Reload from DONE: after done, pulse start and write 16 words of 4'h7 -> done drops, busy rises, writes restart at waddr=0, done reasserts after 16 handshakes.
6. Reset mid-load: assert reset in the cycle after the 8th handshake -> we=0 from the next edge onward, state IDLE. A subsequent start reloads from waddr=0.

Source files
------------

// File: rtl/mem_loader.sv
// mem_loader: writer-side companion to the max-finder datapath.
// Accepts a stream of data words over a valid/ready handshake and writes them to
// sequential addresses 0..MAXADDR of the data memory through a registered write port.
// It then raises done so the max-finder can scan the filled memory.
//
// Ports:
//   clk       - clock; all state updates on the rising edge
//   reset     - synchronous, active-high reset
//   start     - pulse: begin a load at address 0 (honoured in IDLE and DONE only)
//   in_valid  - producer has a word on in_data
//   in_data   - word to write
//   in_ready  - loader accepts a word this cycle (from state only)
//   we        - memory write enable (registered, one cycle after the handshake)
//   waddr     - memory write address (registered, held while we=0)
//   wdata     - memory write data (registered, held while we=0)
//   busy      - FSM is in LOAD
//   done      - load complete; memory holds MAXADDR+1 new words
module mem_loader #(
    parameter int unsigned   AW      = 4,
    parameter int unsigned   DW      = 4,
    parameter logic [AW-1:0] MAXADDR = 4'hf
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          handshake;

    logic          we_q;
    logic [AW-1:0] waddr_q;
    logic [DW-1:0] wdata_q;

    // Next-state and address counter.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        handshake = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                    addr_d  = '0;
                end
            end
            StLoad: begin
                // start is deliberately ignored here; the load runs to completion.
                handshake = in_valid;
                if (in_valid) begin
                    // The top address exits to DONE, so the increment never wraps.
                    if (addr_q == MAXADDR) begin
                        state_d = StDone;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            StDone: begin
                if (start) begin
                    state_d = StLoad;
                    addr_d  = '0;
                end
            end
            default: begin
                state_d = StIdle;
                addr_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // Registered write port: a handshake in cycle N is presented in cycle N+1.
    // Reset drops any write captured in the previous cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q <= handshake;
            if (handshake) begin
                waddr_q <= addr_q;
                wdata_q <= in_data;
            end
        end
    end

    assign in_ready = (state_q == StLoad);
    assign busy     = (state_q == StLoad);
    assign done     = (state_q == StDone);
    assign we       = we_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader. A small reference model of the controller tracks
// state and address; each handshake pushes the expected {waddr, wdata} onto a scoreboard
// queue, and each write the DUT presents pops and compares against it.
module tb_mem_loader;

    localparam int AW = 4;
    localparam int DW = 4;
    localparam int MAXA = 15;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_DONE = 2;

    logic          clk;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          busy;
    logic          done;

    mem_loader #(
        .AW     (AW),
        .DW     (DW),
        .MAXADDR(4'hf)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .in_valid(in_valid),
        .in_data (in_data),
        .in_ready(in_ready),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks   = 0;
    int n_failures = 0;

    // Reference model and scoreboard.
    int                  m_state;
    int                  m_addr;
    logic [AW+DW-1:0]    sb_q[$];
    int                  n_writes;
    int                  cyc;
    int                  first_hs;
    int                  done_at;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, check in_ready, advance the model, then check the
    // registered write port and status outputs after the edge.
    task automatic step(input logic st, input logic vld, input logic rst,
                        input logic [DW-1:0] d);
        logic hs;
        logic [AW+DW-1:0] ent;
        start    = st;
        in_valid = vld;
        reset    = rst;
        in_data  = d;
        #1;
        check_eq("in_ready", {31'b0, in_ready}, {31'b0, m_state == M_LOAD});
        hs = vld && (m_state == M_LOAD) && !rst;
        if (hs) begin
            sb_q.push_back({m_addr[AW-1:0], d});
            if (first_hs < 0) first_hs = cyc;
        end
        if (rst) begin
            m_state = M_IDLE;
            m_addr  = 0;
        end else begin
            case (m_state)
                M_IDLE: if (st) begin m_state = M_LOAD; m_addr = 0; end
                M_LOAD: if (hs) begin
                    if (m_addr == MAXA) m_state = M_DONE;
                    else m_addr = m_addr + 1;
                end
                default: if (st) begin m_state = M_LOAD; m_addr = 0; end
            endcase
        end
        @(posedge clk);
        #1;
        cyc++;
        check_eq("we", {31'b0, we}, {31'b0, hs});
        if (we === 1'b1) begin
            n_writes++;
            if (sb_q.size() == 0) begin
                check_eq("unexpected_write", 32'd1, 32'd0);
            end else begin
                ent = sb_q.pop_front();
                check_eq("waddr", {28'b0, waddr}, {28'b0, ent[AW+DW-1:DW]});
                check_eq("wdata", {28'b0, wdata}, {28'b0, ent[DW-1:0]});
            end
        end
        if (rst) sb_q.delete();
        check_eq("busy", {31'b0, busy}, {31'b0, m_state == M_LOAD});
        check_eq("done", {31'b0, done}, {31'b0, m_state == M_DONE});
        if (done === 1'b1 && done_at < 0) done_at = cyc;
    endtask

    initial begin
        m_state  = M_IDLE;
        m_addr   = 0;
        n_writes = 0;
        cyc      = 0;
        first_hs = -1;
        done_at  = -1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        reset    = 1'b1;

        // 1. Reset then idle; in_valid is ignored outside LOAD.
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check_eq("rst_we", {31'b0, we}, 32'd0);
        check_eq("rst_busy", {31'b0, busy}, 32'd0);
        check_eq("rst_done", {31'b0, done}, 32'd0);
        check_eq("rst_waddr", {28'b0, waddr}, 32'd0);
        check_eq("rst_wdata", {28'b0, wdata}, 32'd0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 4'(i + 3));
        check_eq("idle_writes", n_writes, 0);

        // 2. Full streaming load; start on the final handshake must be ignored.
        n_writes = 0;
        step(1'b1, 1'b0, 1'b0, 4'h0);
        for (int i = 0; i < 16; i++) step((i == 15), 1'b1, 1'b0, 4'(15 - i));
        check_eq("load_writes", n_writes, 16);
        check_eq("load_done", {31'b0, done}, 32'd1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 4'h9);
        check_eq("done_hold_writes", n_writes, 16);

        // 3. Back-pressure: in_valid every other cycle.
        n_writes = 0;
        step(1'b1, 1'b0, 1'b0, 4'h0);
        first_hs = -1;
        done_at  = -1;
        for (int i = 0; i < 64 && done_at < 0; i++) begin
            step(1'b0, (i % 2 == 0), 1'b0, 4'($urandom_range(0, 15)));
        end
        check_eq("bp_writes", n_writes, 16);
        check_eq("bp_duration", done_at - first_hs, 31);

        // 4. start while loading after 5 words is ignored.
        n_writes = 0;
        step(1'b1, 1'b0, 1'b0, 4'h0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 4'(i));
        step(1'b1, 1'b1, 1'b0, 4'hc);
        for (int i = 0; i < 40 && m_state != M_DONE; i++) step(1'b0, 1'b1, 1'b0, 4'(i));
        step(1'b0, 1'b0, 1'b0, 4'h0);
        check_eq("ign_start_writes", n_writes, 16);

        // 5. Reload from DONE with a constant pattern.
        n_writes = 0;
        step(1'b1, 1'b0, 1'b0, 4'h0);
        check_eq("reload_busy", {31'b0, busy}, 32'd1);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 4'h7);
        check_eq("reload_writes", n_writes, 16);

        // 6. Reset in the cycle after the 8th handshake.
        n_writes = 0;
        step(1'b1, 1'b0, 1'b0, 4'h0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 4'(i + 8));
        step(1'b0, 1'b1, 1'b1, 4'hf);
        check_eq("midrst_we", {31'b0, we}, 32'd0);
        check_eq("midrst_in_ready", {31'b0, in_ready}, 32'd0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 4'h1);
        step(1'b1, 1'b0, 1'b0, 4'h0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 4'(i + 2));
        check_eq("midrst_writes", n_writes, 11);
        check_eq("midrst_waddr", {28'b0, waddr}, 32'd2);
        check_eq("sb_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule
